// File: rtl/pp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pp_ctrl_pkg
// Shared types and constants for the ping-pong frame RAM write controller.
//   - pp_state_t : controller phase (WAIT, CLEAR, DRAW)
//   - BG_DEFAULT : idle value driven on wrData when no write is in progress
// ---------------------------------------------------------------------------
package pp_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } pp_state_t;

    localparam logic [7:0] BG_DEFAULT = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at rr_ptr and
// wraps modulo NREQ; the first valid requester found wins. The pointer
// register itself lives in the parent so the parent decides when to advance.
// Ports:
//   valid     in  NREQ   request vector
//   rr_ptr    in  PTR_W  highest-priority requester index
//   enable    in  1      0 forces no grant
//   grant     out NREQ   one-hot grant (all zero when nothing granted)
//   grant_idx out PTR_W  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] rr_ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx
);

    localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);

    logic [PTR_W:0]   cand_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;
    logic             hit_s;

    // Walk the requesters in priority order; the first valid one latches the grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            cand_s = (cand_s >= NREQ_W) ? (cand_s - NREQ_W) : cand_s;
            idx_s  = cand_s[PTR_W-1:0];
            hit_s  = enable & ~found_s & valid[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/pp_write_ctrl.sv
// ---------------------------------------------------------------------------
// pp_write_ctrl
// Write-side controller for the ping-pong frame RAM. After every frameStart
// it optionally clears the new back buffer to bgColor (one address per
// cycle), then shares the single RAM write port among NREQ drawing
// requesters with round-robin valid/ready arbitration. No write is issued on
// the swap cycle, so nothing lands in the buffer becoming the front buffer.
//
// Optional build macro: PPW_STATS_EN adds wrCount and clearOverrun.
//
// Ports:
//   vgaclk       in  1            pixel clock
//   rst          in  1            asynchronous active-high reset
//   frameStart   in  1            one-cycle swap pulse
//   clearEn      in  1            run CLEAR after frameStart when 1
//   bgColor      in  8            clear value
//   reqValid     in  NREQ         per-requester write request
//   reqAddr      in  NREQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W]
//   reqData      in  NREQ*8       requester i data at [i*8 +: 8]
//   reqReady     out NREQ         one-hot grant
//   we           out 1            RAM write enable
//   wrAddr       out ADDR_W       RAM write address
//   wrData       out 8            RAM write data
//   clearing     out 1            high in CLEAR
//   drawOpen     out 1            high in DRAW
//   wrCount      out 16           (PPW_STATS_EN) in-range DRAW writes this frame
//   clearOverrun out 1            (PPW_STATS_EN) sticky: frameStart hit CLEAR
// ---------------------------------------------------------------------------
module pp_write_ctrl
    import pp_ctrl_pkg::*;
#(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10,
    parameter int NREQ   = 4
) (
    input  logic                   vgaclk,
    input  logic                   rst,
    input  logic                   frameStart,
    input  logic                   clearEn,
    input  logic [7:0]             bgColor,
    input  logic [NREQ-1:0]        reqValid,
    input  logic [NREQ*ADDR_W-1:0] reqAddr,
    input  logic [NREQ*8-1:0]      reqData,
    output logic [NREQ-1:0]        reqReady,
    output logic                   we,
    output logic [ADDR_W-1:0]      wrAddr,
    output logic [7:0]             wrData,
    output logic                   clearing,
    output logic                   drawOpen
`ifdef PPW_STATS_EN
    ,
    output logic [15:0]            wrCount,
    output logic                   clearOverrun
`endif
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_REQ   = PTR_W'(NREQ - 1);

    pp_state_t         state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic [PTR_W-1:0]  rr_ptr_r;

    logic [NREQ-1:0]   grant_s;
    logic [PTR_W-1:0]  grant_idx_s;
    logic              any_grant_s;
    logic              arb_en_s;
    logic [ADDR_W-1:0] g_addr_s;
    logic [7:0]        g_data_s;
    logic              g_in_range_s;

    logic              we_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [7:0]        wr_data_s;
    logic [NREQ-1:0]   req_ready_s;

    // The swap cycle never grants, so arbitration is gated by frameStart too.
    assign arb_en_s = (state_r == DRAW) & ~frameStart;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .valid     (reqValid),
        .rr_ptr    (rr_ptr_r),
        .enable    (arb_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign any_grant_s  = |grant_s;
    assign g_addr_s     = reqAddr[grant_idx_s*ADDR_W +: ADDR_W];
    assign g_data_s     = reqData[grant_idx_s*8 +: 8];
    // Out-of-range requests are still handshaken but silently dropped.
    assign g_in_range_s = ({1'b0, g_addr_s} < DEPTH_W);

    // Write-port mux: clear engine in CLEAR, granted requester in DRAW.
    always_comb begin
        we_s        = 1'b0;
        wr_addr_s   = '0;
        wr_data_s   = BG_DEFAULT;
        req_ready_s = '0;
        case (state_r)
            CLEAR: begin
                if (!frameStart) begin
                    we_s      = 1'b1;
                    wr_addr_s = clr_addr_r;
                    wr_data_s = bgColor;
                end else begin
                    we_s      = 1'b0;
                end
            end
            DRAW: begin
                req_ready_s = grant_s;
                if (any_grant_s) begin
                    we_s      = g_in_range_s;
                    wr_addr_s = g_addr_s;
                    wr_data_s = g_data_s;
                end else begin
                    we_s      = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    assign we       = we_s;
    assign wrAddr   = wr_addr_s;
    assign wrData   = wr_data_s;
    assign reqReady = req_ready_s;
    assign clearing = (state_r == CLEAR);
    assign drawOpen = (state_r == DRAW);

    // Phase sequencing, clear address counter and round-robin pointer.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            state_r    <= WAIT;
            clr_addr_r <= '0;
            rr_ptr_r   <= '0;
        end else if (frameStart) begin
            // Swap restarts the frame from any state, including mid-clear.
            clr_addr_r <= '0;
            state_r    <= clearEn ? CLEAR : DRAW;
        end else begin
            case (state_r)
                WAIT: begin
                    state_r <= WAIT;
                end
                CLEAR: begin
                    if (clr_addr_r == LAST_ADDR) begin
                        clr_addr_r <= '0;
                        state_r    <= DRAW;
                    end else begin
                        clr_addr_r <= clr_addr_r + 1'b1;
                    end
                end
                DRAW: begin
                    if (any_grant_s) begin
                        rr_ptr_r <= (grant_idx_s == LAST_REQ) ? '0 : grant_idx_s + 1'b1;
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                end
                default: begin
                    state_r <= WAIT;
                end
            endcase
        end
    end

`ifdef PPW_STATS_EN
    logic [15:0] wr_count_r;
    logic        clear_overrun_r;

    // Per-frame count of committed DRAW writes, saturating.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            wr_count_r <= 16'h0000;
        end else if (frameStart) begin
            wr_count_r <= 16'h0000;
        end else if ((state_r == DRAW) && we_s && (wr_count_r != 16'hFFFF)) begin
            wr_count_r <= wr_count_r + 16'h0001;
        end else begin
            wr_count_r <= wr_count_r;
        end
    end

    // Sticky flag: a swap arrived before the clear had finished.
    always_ff @(posedge vgaclk or posedge rst) begin
        if (rst) begin
            clear_overrun_r <= 1'b0;
        end else if (frameStart && (state_r == CLEAR)) begin
            clear_overrun_r <= 1'b1;
        end else begin
            clear_overrun_r <= clear_overrun_r;
        end
    end

    assign wrCount      = wr_count_r;
    assign clearOverrun = clear_overrun_r;
`endif

endmodule
